// File: rtl/dtree_pkg.sv
// Shared definitions for the sequential decision-tree classifier.
// Contents:
//   state_e     - FSM state encoding (StIdle, StWalk, StDone)
//   idx_w       - index width helper (clog2, minimum 1)
//   off_*/node_w- node-word field offsets and total width
//   pack_node   - builds a node word (zero-extended to NodeWMax bits)
// Node word, MSB to LSB: leaf | feat_idx | shift | thr | left | right.
package dtree_pkg;

  typedef enum logic [1:0] {StIdle, StWalk, StDone} state_e;

  localparam int unsigned NodeWMax = 128;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned off_left(input int unsigned n_nodes);
    return idx_w(n_nodes);
  endfunction

  function automatic int unsigned off_thr(input int unsigned n_nodes);
    return 2 * idx_w(n_nodes);
  endfunction

  function automatic int unsigned off_shift(input int unsigned feat_w, input int unsigned n_nodes);
    return off_thr(n_nodes) + feat_w;
  endfunction

  function automatic int unsigned off_fidx(input int unsigned feat_w, input int unsigned n_nodes);
    return off_shift(feat_w, n_nodes) + idx_w(feat_w);
  endfunction

  function automatic int unsigned off_leaf(input int unsigned n_feat, input int unsigned feat_w,
                                           input int unsigned n_nodes);
    return off_fidx(feat_w, n_nodes) + idx_w(n_feat);
  endfunction

  function automatic int unsigned node_w(input int unsigned n_feat, input int unsigned feat_w,
                                         input int unsigned n_nodes);
    return off_leaf(n_feat, feat_w, n_nodes) + 1;
  endfunction

  // Field value masked to its width, zero-extended.
  function automatic logic [NodeWMax-1:0] fld(input int unsigned v, input int unsigned wd);
    return NodeWMax'(v) & ((NodeWMax'(1) << wd) - NodeWMax'(1));
  endfunction

  function automatic logic [NodeWMax-1:0] pack_node(
    input int unsigned n_feat, input int unsigned feat_w, input int unsigned n_nodes,
    input logic leaf, input int unsigned feat_idx, input int unsigned shift,
    input int unsigned thr, input int unsigned left, input int unsigned right);
    logic [NodeWMax-1:0] w;
    w = fld(right, idx_w(n_nodes));
    w |= fld(left, idx_w(n_nodes)) << off_left(n_nodes);
    w |= fld(thr, feat_w) << off_thr(n_nodes);
    w |= fld(shift, idx_w(feat_w)) << off_shift(feat_w, n_nodes);
    w |= fld(feat_idx, idx_w(n_feat)) << off_fidx(feat_w, n_nodes);
    w |= NodeWMax'(leaf) << off_leaf(n_feat, feat_w, n_nodes);
    return w;
  endfunction

endpackage

// File: rtl/dtree_node_cmp.sv
// Combinational evaluation of one internal tree node.
// Build option: DTREE_APPROX_CMP_EN honours the shift field; otherwise it is ignored.
// Ports:
//   feat     in  packed feature vector, feature i at [i*FEAT_W +: FEAT_W]
//   feat_idx in  feature selected by the node (out-of-range selects 0)
//   shift    in  right-shift applied to the feature before the compare
//   thr      in  threshold, unsigned
//   left     in  next node when (f >> shift) <= thr
//   right    in  next node otherwise
//   next_ptr out selected next node
module dtree_node_cmp import dtree_pkg::*; #(
  parameter int unsigned N_FEAT  = 16,
  parameter int unsigned FEAT_W  = 8,
  parameter int unsigned N_NODES = 64,
  localparam int unsigned FI_W    = idx_w(N_FEAT),
  localparam int unsigned SH_W    = idx_w(FEAT_W),
  localparam int unsigned NADDR_W = idx_w(N_NODES)
) (
  input  logic [N_FEAT*FEAT_W-1:0] feat,
  input  logic [FI_W-1:0]          feat_idx,
  input  logic [SH_W-1:0]          shift,
  input  logic [FEAT_W-1:0]        thr,
  input  logic [NADDR_W-1:0]       left,
  input  logic [NADDR_W-1:0]       right,
  output logic [NADDR_W-1:0]       next_ptr
);

  logic [FEAT_W-1:0] f;
  logic [FEAT_W-1:0] f_cmp;

  // Mux by equality so an index beyond N_FEAT falls through to zero.
  always_comb begin
    f = '0;
    for (int i = 0; i < int'(N_FEAT); i++) begin
      if (feat_idx == FI_W'(i)) f = feat[i*FEAT_W +: FEAT_W];
    end
  end

`ifdef DTREE_APPROX_CMP_EN
  assign f_cmp = f >> shift;
`else
  logic unused_shift;
  assign unused_shift = ^shift;
  assign f_cmp = f;
`endif

  assign next_ptr = (f_cmp <= thr) ? left : right;

endmodule

// File: rtl/dtree_seq_eval.sv
// Sequential programmable decision-tree classifier, one node per clock.
// Build option: DTREE_APPROX_CMP_EN enables the per-node feature shift.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   sample handshake, in_feat packed features
//   out_valid/out_ready result handshake, out_class/out_err result
//   cfg_we/addr/data    node-table write, honoured only while idle
module dtree_seq_eval import dtree_pkg::*; #(
  parameter int unsigned N_FEAT        = 16,
  parameter int unsigned FEAT_W        = 8,
  parameter int unsigned CLASS_W       = 4,
  parameter int unsigned N_NODES       = 64,
  parameter int unsigned MAX_DEPTH     = 16,
  parameter int unsigned DEFAULT_CLASS = 0,
  localparam int unsigned NADDR_W = idx_w(N_NODES),
  localparam int unsigned NODE_W  = node_w(N_FEAT, FEAT_W, N_NODES)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_FEAT*FEAT_W-1:0] in_feat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CLASS_W-1:0]       out_class,
  output logic                     out_err,
  input  logic                     cfg_we,
  input  logic [NADDR_W-1:0]       cfg_addr,
  input  logic [NODE_W-1:0]        cfg_data
);

  localparam int unsigned FI_W      = idx_w(N_FEAT);
  localparam int unsigned SH_W      = idx_w(FEAT_W);
  localparam int unsigned STEP_W    = idx_w(MAX_DEPTH + 1);
  localparam int unsigned OFF_LEFT  = off_left(N_NODES);
  localparam int unsigned OFF_THR   = off_thr(N_NODES);
  localparam int unsigned OFF_SHIFT = off_shift(FEAT_W, N_NODES);
  localparam int unsigned OFF_FIDX  = off_fidx(FEAT_W, N_NODES);
  localparam int unsigned OFF_LEAF  = off_leaf(N_FEAT, FEAT_W, N_NODES);

  state_e                   state_q;
  logic [NODE_W-1:0]        table_q [N_NODES];
  logic [N_FEAT*FEAT_W-1:0] feat_q;
  logic [NADDR_W-1:0]       ptr_q;
  logic [STEP_W-1:0]        step_q;
  logic                     in_ready_q;
  logic                     out_valid_q;
  logic [CLASS_W-1:0]       out_class_q;
  logic                     out_err_q;

  logic [NODE_W-1:0]        node;
  logic [FEAT_W-1:0]        node_thr;
  logic [NADDR_W-1:0]       next_ptr;

  // Pointers past the table (non-power-of-two N_NODES) read as the zero node.
  assign node     = (int'(ptr_q) < int'(N_NODES)) ? table_q[ptr_q] : '0;
  assign node_thr = node[OFF_THR +: FEAT_W];

  dtree_node_cmp #(
    .N_FEAT  (N_FEAT),
    .FEAT_W  (FEAT_W),
    .N_NODES (N_NODES)
  ) u_node_cmp (
    .feat     (feat_q),
    .feat_idx (node[OFF_FIDX +: FI_W]),
    .shift    (node[OFF_SHIFT +: SH_W]),
    .thr      (node_thr),
    .left     (node[OFF_LEFT +: NADDR_W]),
    .right    (node[0 +: NADDR_W]),
    .next_ptr (next_ptr)
  );

  // Table is writable only while idle so a walk always sees a frozen tree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_NODES); i++) table_q[i] <= '0;
    end else if (state_q == StIdle && cfg_we && int'(cfg_addr) < int'(N_NODES)) begin
      table_q[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      feat_q      <= '0;
      ptr_q       <= '0;
      step_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            feat_q     <= in_feat;
            ptr_q      <= '0;
            step_q     <= '0;
            in_ready_q <= 1'b0;
            state_q    <= StWalk;
          end
        end
        StWalk: begin
          step_q <= step_q + 1'b1;
          if (node[OFF_LEAF]) begin
            out_class_q <= node_thr[CLASS_W-1:0];
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else if (step_q == STEP_W'(MAX_DEPTH - 1)) begin
            // This was the MAX_DEPTH-th node visited and it is still not a leaf.
            out_class_q <= CLASS_W'(DEFAULT_CLASS);
            out_err_q   <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            ptr_q <= next_ptr;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_dtree_seq_eval.sv
// Scoreboard bench for dtree_seq_eval: the driver pushes the expected result
// (class, err, latency from the accept cycle) and a negedge monitor pops and
// compares whenever out_valid appears, then checks it stays stable while held.
module tb_dtree_seq_eval;
  import dtree_pkg::*;

  localparam int unsigned N_FEAT        = 16;
  localparam int unsigned FEAT_W        = 8;
  localparam int unsigned CLASS_W       = 4;
  localparam int unsigned N_NODES       = 64;
  localparam int unsigned MAX_DEPTH     = 16;
  localparam int unsigned DEFAULT_CLASS = 0;
  localparam int unsigned NADDR_W       = idx_w(N_NODES);
  localparam int unsigned NODE_W        = node_w(N_FEAT, FEAT_W, N_NODES);

  logic                     clk;
  logic                     rst_n;
  logic                     in_valid;
  logic                     in_ready;
  logic [N_FEAT*FEAT_W-1:0] in_feat;
  logic                     out_valid;
  logic                     out_ready;
  logic [CLASS_W-1:0]       out_class;
  logic                     out_err;
  logic                     cfg_we;
  logic [NADDR_W-1:0]       cfg_addr;
  logic [NODE_W-1:0]        cfg_data;

  dtree_seq_eval #(
    .N_FEAT        (N_FEAT),
    .FEAT_W        (FEAT_W),
    .CLASS_W       (CLASS_W),
    .N_NODES       (N_NODES),
    .MAX_DEPTH     (MAX_DEPTH),
    .DEFAULT_CLASS (DEFAULT_CLASS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_feat   (in_feat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_err   (out_err),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cls;
    int err;
    int lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  bit   seen     = 1'b0;

`ifdef DTREE_APPROX_CMP_EN
  localparam int ApproxLeftCls = 7;
`else
  localparam int ApproxLeftCls = 9;
`endif

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: cycle index advances once per clock; the accept cycle is cycle 0.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      seen = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_cyc = cyc;
      if (out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          if (exp_q.size() == 0) begin
            check("unexpected_result", 1, 0);
            cur = '{cls: out_class, err: out_err, lat: 0};
          end else begin
            cur = exp_q.pop_front();
            check("class", int'(out_class), cur.cls);
            check("err", int'(out_err), cur.err);
            check("latency", cyc - acc_cyc, cur.lat);
          end
        end else begin
          check("class_hold", int'(out_class), cur.cls);
          check("err_hold", int'(out_err), cur.err);
          check("in_ready_in_done", int'(in_ready), 0);
        end
        if (out_ready) seen = 1'b0;
      end
    end
  end

  function automatic logic [NODE_W-1:0] nd(input logic leaf, input int unsigned fi,
                                           input int unsigned sh, input int unsigned thr,
                                           input int unsigned l, input int unsigned r);
    return NODE_W'(pack_node(N_FEAT, FEAT_W, N_NODES, leaf, fi, sh, thr, l, r));
  endfunction

  function automatic logic [N_FEAT*FEAT_W-1:0] fv(input int unsigned f3, input int unsigned other);
    logic [N_FEAT*FEAT_W-1:0] v;
    for (int i = 0; i < int'(N_FEAT); i++) v[i*FEAT_W +: FEAT_W] = FEAT_W'(other);
    v[3*FEAT_W +: FEAT_W] = FEAT_W'(f3);
    return v;
  endfunction

  // Called at posedge+1 while idle.
  task automatic wr(input int unsigned addr, input logic [NODE_W-1:0] data);
    cfg_we   = 1'b1;
    cfg_addr = NADDR_W'(addr);
    cfg_data = data;
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic load_tree3();
    wr(0, nd(1'b0, 3, 0, 4, 1, 2));
    wr(1, nd(1'b1, 0, 0, 7, 0, 0));
    wr(2, nd(1'b1, 0, 0, 9, 0, 0));
  endtask

  // One sample: optional DONE hold with a competing in_valid, optional
  // mid-walk rewrite of node 0 that must be ignored.
  task automatic run(input logic [N_FEAT*FEAT_W-1:0] feat, input int cls, input int err,
                     input int lat, input int hold, input bit walk_wr);
    int t;
    exp_q.push_back('{cls: cls, err: err, lat: lat});
    in_feat  = feat;
    in_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 50);
    if (!in_ready) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (walk_wr) begin
      cfg_we   = 1'b1;
      cfg_addr = '0;
      cfg_data = nd(1'b1, 0, 0, 3, 0, 0);
      @(posedge clk);
      @(posedge clk);
      #1 cfg_we = 1'b0;
    end
    out_ready = (hold == 0);
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) begin
      check("result_timeout", 0, 1);
      void'(exp_q.pop_back());
      out_ready = 1'b1;
      return;
    end
    if (hold > 0) begin
      @(posedge clk);
      #1 in_valid = 1'b1;
      repeat (hold) @(posedge clk);
      #1 in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_feat   = '0;
    out_ready = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_class", int'(out_class), 0);
    check("rst_out_err", int'(out_err), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    // Zero table: self-loop at node 0, depth-guard exit.
    run(fv(0, 0), DEFAULT_CLASS, 1, MAX_DEPTH + 1, 0, 1'b0);

    load_tree3();
    run(fv(4, 0), 7, 0, 3, 0, 1'b0);
    run(fv(5, 0), 9, 0, 3, 0, 1'b0);
    run(fv(0, 0), 7, 0, 3, 0, 1'b0);
    run(fv(255, 0), 9, 0, 3, 0, 1'b0);
    run(fv(4, 255), 7, 0, 3, 0, 1'b0);

    // Result held five cycles with a competing sample offered.
    run(fv(5, 0), 9, 0, 3, 5, 1'b0);

    // Mid-walk table write is ignored, both now and for the next sample.
    run(fv(4, 0), 7, 0, 3, 0, 1'b1);
    run(fv(4, 0), 7, 0, 3, 0, 1'b0);
    run(fv(5, 0), 9, 0, 3, 0, 1'b0);

    // Shifted compare: 0x0F>>4 = 0 <= 0 only when the shift is honoured.
    wr(0, nd(1'b0, 3, 4, 0, 1, 2));
    run(fv(8'h0F, 0), ApproxLeftCls, 0, 3, 0, 1'b0);
    run(fv(8'h10, 0), 9, 0, 3, 0, 1'b0);

    // Leaf at depth MAX_DEPTH-1 still classifies; class is thr[3:0].
    for (int i = 0; i < 15; i++) wr(i, nd(1'b0, 0, 0, 255, i + 1, i + 1));
    wr(15, nd(1'b1, 0, 0, 8'h35, 0, 0));
    run(fv(0, 0), 5, 0, MAX_DEPTH + 1, 0, 1'b0);
    // One level deeper trips the guard.
    wr(15, nd(1'b0, 0, 0, 255, 16, 16));
    wr(16, nd(1'b1, 0, 0, 8'hA6, 0, 0));
    run(fv(0, 0), DEFAULT_CLASS, 1, MAX_DEPTH + 1, 0, 1'b0);

    // Reset in the middle of a walk, with out_class still holding 9.
    load_tree3();
    run(fv(5, 0), 9, 0, 3, 0, 1'b0);
    in_feat  = fv(4, 0);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_class", int'(out_class), 0);
    check("midrst_out_err", int'(out_err), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Table was cleared by reset.
    run(fv(5, 0), DEFAULT_CLASS, 1, MAX_DEPTH + 1, 0, 1'b0);
    load_tree3();
    run(fv(5, 0), 9, 0, 3, 0, 1'b0);
    run(fv(3, 0), 7, 0, 3, 0, 1'b0);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dtree_seq_eval.md
# dtree_seq_eval

Sequential, programmable decision-tree classifier for the printed-classifier flow. The tree is held in a run-time-loadable node table instead of hard-wired comparators. One node is evaluated per clock. A sample is accepted over a valid/ready handshake and its class is returned over a second handshake. It is the parametrised successor of the per-dataset combinational trees: it supports arbitrary feature count, widths and depth, and it adds a depth guard.

## Interface
- N_FEAT, 16: number of input features.
- FEAT_W, 8: feature and threshold width (unsigned).
- CLASS_W, 4: class label width; must be ≤ FEAT_W.
- N_NODES, 64: node-table entries; NADDR_W = clog2(N_NODES).
- MAX_DEPTH, 16: maximum number of nodes visited per sample before the error exit.
- DEFAULT_CLASS, 0: class reported on error.
- clk  in  1  clock; one clock domain, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  sample present.
- in_ready  out  1  block can accept a sample.
- in_feat  in  N_FEAT*FEAT_W  packed features; feature i is at [i*FEAT_W +: FEAT_W].
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_class  out  CLASS_W  predicted class.
- out_err  out  1  depth guard tripped; out_class = DEFAULT_CLASS.
- cfg_we  in  1  node-table write strobe.
- cfg_addr  in  NADDR_W  node index.
- cfg_data  in  NODE_W  node word.

Node word, MSB to LSB:
- leaf (1 bit)
- feat_idx (clog2(N_FEAT))
- shift (clog2(FEAT_W))
- thr (FEAT_W)
- left (NADDR_W)
- right (NADDR_W)

For a leaf, the class is thr[CLASS_W-1:0].

## Operation
- FSM states: IDLE, WALK, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_feat, set node pointer to 0, clear step counter, go to WALK.
- WALK: each cycle read node[ptr] and increment the step counter.
  - leaf=1: register class, out_err=0, go to DONE.
  - Otherwise compute f = in_feat[feat_idx].
    - cmp true when (f >> shift) ≤ thr (unsigned, FEAT_W bits). shift applies only with the macro; see Configuration.
    - ptr ← cmp ? left : right.
  - feat_idx ≥ N_FEAT: f is treated as 0.
  - Step counter reaches MAX_DEPTH on a non-leaf: out_class=DEFAULT_CLASS, out_err=1, go to DONE.
- DONE:
  - out_valid=1; out_class and out_err are held stable.
  - On out_ready: go to IDLE.
- Config writes:
  - Take effect only in IDLE: node[cfg_addr] ← cfg_data on the same edge.
  - cfg_we in WALK or DONE is ignored, so the table cannot change mid-sample.
  - cfg_we and in_valid in the same IDLE cycle: the write and the accept both happen. The accepted sample sees the new node.
- Reset (also mid-walk): state=IDLE, out_valid=0, out_class=0, out_err=0, in_ready=1 once reset deasserts. All node-table entries reset to zero.
  - The zero table self-loops at node 0 and exits through the depth guard.

## Timing
- Accept edge at cycle 0. Node at depth d (root d=0) is evaluated in cycle d+1.
- A leaf at depth d gives out_valid high from cycle d+2.
- Best case, root leaf: result at cycle 2.
- Depth-guard exit: out_valid at cycle MAX_DEPTH+1.
- in_ready is low from cycle 1 until the cycle after the DONE handshake. There is no overlap of samples.
- out_valid with out_ready high in the same cycle: the result is consumed and in_ready returns high on the next cycle.
- All outputs are registered.

## Configuration
- DTREE_APPROX_CMP_EN defined:
  - The shift field is honoured: feature bits are truncated before the compare, matching the precision-scaled printed trees.
- Undefined:
  - The shift field is ignored (treated as 0) and its right-shifter is removed.
  - Node-word layout is unchanged, so tables stay portable.

## Structure
- Shared package dtree_pkg:
  - node field widths and offsets functions;
  - FSM state enum;
  - node-word packing helper.
- Sub-module dtree_node_cmp: combinational feature select, optional shift, ≤ compare and next-pointer mux. The top keeps the FSM, the table and the handshakes.

## Test plan
- Reset only, then sample all-zero -> out_err=1, out_class=DEFAULT_CLASS, out_valid at cycle MAX_DEPTH+1.
- Load node0={leaf=0,feat 3,thr 4,left 1,right 2}, node1=leaf class 7, node2=leaf class 9.
  - Feature3=4 -> class 7 at cycle 3.
  - Feature3=5 -> class 9.
- With DTREE_APPROX_CMP_EN: node0 shift=4, thr 0.
  - Feature3=0x0F -> left.
  - Feature3=0x10 -> right.
  - Without the macro, 0x0F -> right.
- out_ready held low 5 cycles in DONE -> out_valid and out_class stable; in_ready=0; a new in_valid is not accepted.
- cfg_we to node0 during WALK -> ignored; the sample's result is unchanged and a follow-up read behaves as the old table.
- rst_n asserted mid-WALK -> outputs 0 immediately; the next sample is evaluated from node 0.
